// File: rtl/axi4_lite_gpio_slave_pkg.sv
// Register map, response codes and FSM state types shared by the
// axi4_lite_gpio_slave RTL (package axi4_lite_addr_map_package).
package axi4_lite_addr_map_package;

  // Register indices decoded from address bits [4:2].
  localparam logic [2:0] REG_DATA_OUT   = 3'd0;
  localparam logic [2:0] REG_DIR        = 3'd1;
  localparam logic [2:0] REG_DATA_IN    = 3'd2;
  localparam logic [2:0] REG_IRQ_STATUS = 3'd3;
  localparam logic [2:0] REG_IRQ_MASK   = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_e;
  typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_e;

  // True when an index selects an implemented register.
  function automatic logic reg_mapped(input logic [2:0] idx, input logic irq_en);
    return (idx == REG_DATA_OUT) || (idx == REG_DIR) || (idx == REG_DATA_IN) ||
           (irq_en && ((idx == REG_IRQ_STATUS) || (idx == REG_IRQ_MASK)));
  endfunction

  // Expand a 4-bit byte strobe into a 32-bit bit-enable mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{strb[i]}};
    return mask;
  endfunction

endpackage

// File: rtl/axi4_lite_gpio_slave_sync.sv
// gpio_input_sync: two-flop synchronizer for asynchronous GPIO pins plus a
// rising-edge detector on the synchronized value. The edge detector exists
// only when AXI4_LITE_GPIO_IRQ_EN is defined; otherwise rise is tied to 0.
module gpio_input_sync #(
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_sync,
  output logic [GPIO_WIDTH-1:0] rise
);

  logic [GPIO_WIDTH-1:0] meta;

  // Two-stage synchronizer; the second stage is the architectural DATA_IN value.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta      <= '0;
      gpio_sync <= '0;
    end else begin
      meta      <= gpio_in;
      gpio_sync <= meta;
    end
  end

`ifdef AXI4_LITE_GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] sync_prev;

  // Delayed copy of the synchronized value for 0->1 detection.
  always_ff @(posedge clk) begin
    if (rst) sync_prev <= '0;
    else     sync_prev <= gpio_sync;
  end

  assign rise = gpio_sync & ~sync_prev;
`else
  assign rise = '0;
`endif

endmodule

// File: rtl/axi4_lite_gpio_slave.sv
// axi4_lite_gpio_slave: AXI4-Lite register slave for a GPIO block with
// DATA_OUT, DIR, DATA_IN and (optionally) IRQ_STATUS / IRQ_MASK registers.
// Define AXI4_LITE_GPIO_IRQ_EN to build the edge interrupt logic; without it
// indices 3 and 4 answer SLVERR and irq is tied low.
module axi4_lite_gpio_slave
  import axi4_lite_addr_map_package::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

`ifdef AXI4_LITE_GPIO_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  w_state_e              w_state, w_state_nxt;
  r_state_e              r_state, r_state_nxt;
  logic [GPIO_WIDTH-1:0] data_out, dir, data_in, irq_status, irq_mask, gpio_rise;
  logic                  wr_fire, rd_fire;
  logic [2:0]            wr_idx, rd_idx;
  logic [31:0]           wr_strb_mask, wr_masked, rd_word;
  logic [GPIO_WIDTH-1:0] wr_bits, wr_keep;
  logic                  unused_bits;

  // Handshakes: ready only in the idle state and never while in reset.
  assign awready = (w_state == W_IDLE) && !rst;
  assign wready  = (w_state == W_IDLE) && !rst;
  assign arready = (r_state == R_IDLE) && !rst;
  assign bvalid  = (w_state == W_RESP);
  assign rvalid  = (r_state == R_DATA);
  assign wr_fire = awready && awvalid && wvalid;
  assign rd_fire = arready && arvalid;

  assign wr_idx       = awaddr[4:2];
  assign rd_idx       = araddr[4:2];
  assign wr_strb_mask = strb_to_mask(wstrb);
  assign wr_masked    = wdata & wr_strb_mask;
  assign wr_bits      = wr_masked[GPIO_WIDTH-1:0];
  assign wr_keep      = wr_strb_mask[GPIO_WIDTH-1:0];
  // Address bits outside [4:2] and data bits above GPIO_WIDTH are don't-care.
  assign unused_bits  = ^{awaddr, araddr, wr_masked, wr_strb_mask};

  assign gpio_out = data_out;
  assign gpio_oe  = dir;

  gpio_input_sync #(
    .GPIO_WIDTH(GPIO_WIDTH)
  ) u_input_sync (
    .clk      (clk),
    .rst      (rst),
    .gpio_in  (gpio_in),
    .gpio_sync(data_in),
    .rise     (gpio_rise)
  );

  // Write FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  // Write FSM next state: accept AW and W together, hold B until bready.
  always_comb begin
    // NOTE: default assigned first so no path infers a latch.
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (wr_fire) w_state_nxt = W_RESP;
      W_RESP:  if (bready)  w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write response and read/write register updates on an accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      bresp    <= RESP_OKAY;
      data_out <= '0;
      dir      <= '0;
    end else if (wr_fire) begin
      bresp <= reg_mapped(wr_idx, IRQ_EN) ? RESP_OKAY : RESP_SLVERR;
      if (wr_idx == REG_DATA_OUT) data_out <= (data_out & ~wr_keep) | wr_bits;
      if (wr_idx == REG_DIR)      dir      <= (dir & ~wr_keep) | wr_bits;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  // Read FSM next state: one address per response, hold R until rready.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (rd_fire) r_state_nxt = R_DATA;
      R_DATA:  if (rready)  r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read mux; bits above GPIO_WIDTH and unmapped indices read as zero.
  always_comb begin
    rd_word = '0;
    case (rd_idx)
      REG_DATA_OUT:   rd_word[GPIO_WIDTH-1:0] = data_out;
      REG_DIR:        rd_word[GPIO_WIDTH-1:0] = dir;
      REG_DATA_IN:    rd_word[GPIO_WIDTH-1:0] = data_in;
      REG_IRQ_STATUS: rd_word[GPIO_WIDTH-1:0] = irq_status;
      REG_IRQ_MASK:   rd_word[GPIO_WIDTH-1:0] = irq_mask;
      default:        rd_word = '0;
    endcase
    if (!reg_mapped(rd_idx, IRQ_EN)) rd_word = '0;
  end

  // Read data capture; sampling pre-edge state gives the pre-write value
  // when a read and a write to the same register are accepted together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (rd_fire) begin
      rdata <= rd_word;
      rresp <= reg_mapped(rd_idx, IRQ_EN) ? RESP_OKAY : RESP_SLVERR;
    end
  end

`ifdef AXI4_LITE_GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] irq_clear;

  assign irq_clear = (wr_fire && (wr_idx == REG_IRQ_STATUS)) ? wr_bits : '0;

  // Interrupt status (W1C, new edge wins over clear), mask, registered irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_status <= '0;
      irq_mask   <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~irq_clear) | gpio_rise;
      if (wr_fire && (wr_idx == REG_IRQ_MASK)) irq_mask <= (irq_mask & ~wr_keep) | wr_bits;
      irq <= |(irq_status & irq_mask);
    end
  end
`else
  logic [GPIO_WIDTH-1:0] unused_rise;

  assign unused_rise = gpio_rise;
  assign irq_status  = '0;
  assign irq_mask    = '0;
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_gpio_slave.sv
// Self-checking bench for axi4_lite_gpio_slave: directed scenarios followed by
// random register traffic. Expected responses are queued at issue time from a
// register-level model; a negedge monitor pops and compares on each handshake.
// Follows AXI4_LITE_GPIO_IRQ_EN the same way the RTL does.
module tb_axi4_lite_gpio_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int G  = 8;
`ifdef AXI4_LITE_GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [31:0] GMASK = (32'h1 << G) - 32'h1;

  logic          clk, rst;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [G-1:0]  gpio_in, gpio_out, gpio_oe;
  logic          irq;

  axi4_lite_gpio_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GPIO_WIDTH(G)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (register level) ----------------
  logic [31:0] m_out, m_dir, m_in, m_status, m_mask;

  function automatic bit m_mapped(input int idx);
    return (idx < 3) || (IRQ_EN && idx < 5);
  endfunction

  function automatic logic [31:0] m_value(input int idx);
    case (idx)
      0: return m_out;
      1: return m_dir;
      2: return m_in;
      3: return m_status;
      4: return m_mask;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] bm, nd;
    bm = byte_mask(s) & GMASK;
    nd = d & bm;
    if (m_mapped(idx)) begin
      case (idx)
        0: m_out    = (m_out & ~bm) | nd;
        1: m_dir    = (m_dir & ~bm) | nd;
        3: m_status = m_status & ~nd;
        4: m_mask   = (m_mask & ~bm) | nd;
        default: ;
      endcase
    end
  endtask

  // ---------------- scoreboard queues and monitor ----------------
  logic [1:0]  exp_b[$];
  logic [1:0]  exp_r_resp[$];
  logic [31:0] exp_r_data[$];
  bit          b_hold, r_hold;
  logic [1:0]  b_prev, r_prev_resp;
  logic [31:0] r_prev_data;

  always @(negedge clk) begin
    if (rst) begin
      b_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (b_hold) begin
        check("b_hold_valid", bvalid, 1);
        check("b_hold_resp", bresp, b_prev);
      end
      if (r_hold) begin
        check("r_hold_valid", rvalid, 1);
        check("r_hold_resp", rresp, r_prev_resp);
        check("r_hold_data", rdata, r_prev_data);
      end
      if (bvalid && bready) begin
        check("b_expected", 32'(exp_b.size() > 0), 1);
        if (exp_b.size() > 0) check("bresp", bresp, exp_b.pop_front());
      end
      if (rvalid && rready) begin
        check("r_expected", 32'(exp_r_resp.size() > 0), 1);
        if (exp_r_resp.size() > 0) begin
          check("rresp", rresp, exp_r_resp.pop_front());
          check("rdata", rdata, exp_r_data.pop_front());
        end
      end
      b_hold      = bvalid && !bready;
      b_prev      = bresp;
      r_hold      = rvalid && !rready;
      r_prev_resp = rresp;
      r_prev_data = rdata;
    end
  end

  // Response-channel backpressure: 0 random, 1 held low, 2 held high.
  int bp_mode = 2;
  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0: begin bready = 1'($urandom_range(0, 1)); rready = 1'($urandom_range(0, 1)); end
        1: begin bready = 1'b0; rready = 1'b0; end
        default: begin bready = 1'b1; rready = 1'b1; end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk_addr(input int idx);
    return ($urandom() & 32'hFFFF_FFE0) | (32'(idx) << 2);
  endfunction

  task automatic issue_write(input int idx, input logic [31:0] d, input logic [3:0] s, input int lead);
    int n;
    exp_b.push_back(m_mapped(idx) ? 2'b00 : 2'b10);
    m_write(idx, d, s);
    @(negedge clk);
    awaddr = mk_addr(idx); wdata = d; wstrb = s; awvalid = 1'b1; wvalid = (lead == 0);
    for (int i = 0; i < lead; i++) begin
      @(negedge clk);
      check("no_early_bvalid", bvalid, 0);
    end
    wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 100) begin @(negedge clk); n++; end
    check("aw_accept", 32'(n < 100), 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bvalid_after_accept", bvalid, 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_b.size() != 0 || exp_r_resp.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check(name, exp_b.size() + exp_r_resp.size(), 0);
  endtask

  task automatic send_write(input int idx, input logic [31:0] d, input logic [3:0] s, input int lead);
    issue_write(idx, d, s, lead);
    drain("write_drain");
  endtask

  task automatic send_read(input int idx);
    int n;
    exp_r_resp.push_back(m_mapped(idx) ? 2'b00 : 2'b10);
    exp_r_data.push_back(m_mapped(idx) ? (m_value(idx) & GMASK) : 32'h0);
    @(negedge clk);
    araddr = mk_addr(idx); arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    check("ar_accept", 32'(n < 100), 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    drain("read_drain");
  endtask

  // Read and write of the same register accepted on the same edge.
  task automatic send_rw(input int idx, input logic [31:0] d, input logic [3:0] s);
    int n;
    exp_r_resp.push_back(m_mapped(idx) ? 2'b00 : 2'b10);
    exp_r_data.push_back(m_mapped(idx) ? (m_value(idx) & GMASK) : 32'h0);
    exp_b.push_back(m_mapped(idx) ? 2'b00 : 2'b10);
    m_write(idx, d, s);
    @(negedge clk);
    awaddr = mk_addr(idx); araddr = mk_addr(idx); wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    n = 0;
    while (!(awready && arready) && n < 100) begin @(negedge clk); n++; end
    check("rw_accept", 32'(n < 100), 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    drain("rw_drain");
  endtask

  task automatic set_gpio(input logic [31:0] v);
    if (IRQ_EN) m_status = m_status | (v & ~m_in & GMASK);
    m_in = v & GMASK;
    @(negedge clk);
    gpio_in = v[G-1:0];
    repeat (5) @(negedge clk);
  endtask

  task automatic check_pins();
    repeat (3) @(negedge clk);
    check("gpio_out", gpio_out, m_out[G-1:0]);
    check("gpio_oe", gpio_oe, m_dir[G-1:0]);
    check("irq", irq, 32'(|(m_status & m_mask)));
  endtask

  // Model side of a reset; pins already high re-appear as edges afterwards.
  task automatic m_reset();
    exp_b.delete(); exp_r_resp.delete(); exp_r_data.delete();
    m_out = 0; m_dir = 0; m_mask = 0;
    m_status = IRQ_EN ? m_in : 32'h0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; gpio_in = '0;
    m_in = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_gpio_out", gpio_out, 0);
    check("rst_gpio_oe", gpio_oe, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", awready, 1);
    check("idle_arready", arready, 1);

    // DIR write with no strobes leaves gpio_oe untouched.
    send_write(1, 32'hFF, 4'h0, 0);
    check_pins();

    // DATA_OUT write and readback.
    send_write(0, 32'hA5, 4'hF, 0);
    check_pins();
    send_read(0);

    // AW leads W by three cycles; response held four cycles under backpressure.
    bp_mode = 1;
    repeat (2) @(negedge clk);
    issue_write(0, 32'h3C, 4'hF, 3);
    repeat (4) begin
      @(negedge clk);
      check("bvalid_held", bvalid, 1);
    end
    bp_mode = 2;
    drain("lead_drain");

    // Unmapped read, write to read-only DATA_IN.
    send_read(6);
    send_write(2, 32'h1, 4'hF, 0);
    send_read(2);

    // Edge interrupt on pin 2, then W1C clear.
    send_write(4, 32'h04, 4'hF, 0);
    set_gpio(32'h04);
    send_read(3);
    check_pins();
    send_write(3, 32'h04, 4'hF, 0);
    check_pins();
    send_read(3);

    // Simultaneous read and write of the same register.
    send_rw(0, 32'h5A, 4'hF);
    send_read(0);

    // Reset while the write response is pending.
    bp_mode = 1;
    repeat (2) @(negedge clk);
    issue_write(1, 32'h77, 4'hF, 0);
    check("pre_rst_gpio_oe", gpio_oe, 8'h77);
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    check("abort_bvalid", bvalid, 0);
    check("abort_gpio_out", gpio_out, 0);
    check("abort_awready", awready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", awready, 1);
    bp_mode = 2;
    repeat (5) @(negedge clk);
    check_pins();

    // Random traffic with random response backpressure.
    bp_mode = 0;
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send_write($urandom_range(0, 7), $urandom(), 4'($urandom_range(0, 15)),
                               $urandom_range(0, 2));
        4, 5, 6:    send_read($urandom_range(0, 7));
        7:          set_gpio($urandom());
        8:          send_rw($urandom_range(0, 4), $urandom(), 4'($urandom_range(0, 15)));
        default:    check_pins();
      endcase
    end
    bp_mode = 2;
    drain("final_drain");
    check_pins();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi4_lite_gpio_slave.md
AXI4_LITE_GPIO_SLAVE -- requirements
Module: axi4_lite_gpio_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: AXI data width; only 32 is legal.
REQ-003 SHALL have parameter GPIO_WIDTH, default 8: channel count; legal range 1..32.
REQ-004 SHALL have port clk, input, 1 bit: single clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have AW channel ports: awaddr (input, ADDR_WIDTH), awvalid (input, 1), awready (output, 1).
REQ-007 SHALL have W channel ports: wdata (input, 32), wstrb (input, 4), wvalid (input, 1), wready (output, 1).
REQ-008 SHALL have B channel ports: bresp (output, 2), bvalid (output, 1), bready (input, 1).
REQ-009 SHALL have AR channel ports: araddr (input, ADDR_WIDTH), arvalid (input, 1), arready (output, 1).
REQ-010 SHALL have R channel ports: rdata (output, 32), rresp (output, 2), rvalid (output, 1), rready (input, 1).
REQ-011 SHALL have port gpio_in, input, GPIO_WIDTH: asynchronous pins.
REQ-012 SHALL have port gpio_out, output, GPIO_WIDTH: DATA_OUT register.
REQ-013 SHALL have port gpio_oe, output, GPIO_WIDTH: DIR register; 1 means drive.
REQ-014 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-015 SHALL decode awaddr[4:2] / araddr[4:2] to registers: 0 DATA_OUT (RW), 1 DIR (RW), 2 DATA_IN (RO), 3 IRQ_STATUS (W1C), 4 IRQ_MASK (RW). Upper address bits SHALL be ignored.
REQ-016 SHALL use two independent FSMs: write FSM W_IDLE->W_RESP, read FSM R_IDLE->R_DATA.
REQ-017 SHALL assert awready and wready only in W_IDLE, and SHALL accept a write only when awvalid and wvalid are both high in the same cycle. A lone awvalid or lone wvalid SHALL be held off.
REQ-018 On write acceptance, the register update SHALL take effect next cycle, with bvalid=1 next cycle; bvalid SHALL hold until bready, then the FSM returns to W_IDLE.
REQ-019 SHALL apply wstrb per byte; bits at or above GPIO_WIDTH SHALL be ignored.
REQ-020 SHALL assert arready only in R_IDLE. On arvalid, rdata/rresp SHALL be registered and rvalid=1 next cycle, held stable until rready.
REQ-021 Register bits at or above GPIO_WIDTH SHALL read as 0.
REQ-022 Decode index 5..7 SHALL return resp 2'b10 (SLVERR) with rdata 0 and no state change. Valid accesses, and writes to RO DATA_IN, SHALL return 2'b00; the DATA_IN write SHALL be ignored.
REQ-023 SHALL pass gpio_in through a 2-flop synchronizer; DATA_IN reads the second stage.
REQ-024 A rising edge on synchronized bit n SHALL set IRQ_STATUS[n] one cycle after detection.
REQ-025 irq SHALL equal OR(IRQ_STATUS & IRQ_MASK), registered.
REQ-026 If a W1C clear and a new edge hit the same bit in the same cycle, set SHALL win.
REQ-027 A simultaneous read and write to the same register SHALL return the pre-write value.

Reset
REQ-028 During rst, all registers, synchronizer flops, FSMs (IDLE), bvalid, rvalid, bresp, rresp, rdata, gpio_out, gpio_oe and irq SHALL be 0.
REQ-029 awready, wready and arready SHALL be 0 while rst is high.
REQ-030 Reset mid-transaction SHALL abort the transaction without a response.

Configuration
REQ-031 Macro AXI4_LITE_GPIO_IRQ_EN defined: IRQ_STATUS, IRQ_MASK, edge detect and irq are present as specified.
REQ-032 AXI4_LITE_GPIO_IRQ_EN undefined: indices 3 and 4 decode as unmapped (SLVERR), the edge logic is removed, and irq is tied to 0.

Structure
REQ-033 Register index constants and OKAY/SLVERR response codes SHALL live in axi4_lite_addr_map_package.
REQ-034 The synchronizer and rising-edge detector SHALL be sub-module gpio_input_sync, parametrised by GPIO_WIDTH.

Verification
REQ-035 Write 0x000000A5 to offset 0x0, wstrb 4'hF -> bresp 0, gpio_out=8'hA5; readback rdata=0xA5.
REQ-036 awvalid=1 for 3 cycles before wvalid -> no bvalid until the cycle after both are high; bvalid held 4 cycles with bready=0, stable throughout.
REQ-037 gpio_in[2] rises, mask=0x04 -> IRQ_STATUS=0x04 within 4 cycles, irq=1; write 0x04 to 0xC -> irq=0 next-but-one cycle.
REQ-038 Read offset 0x18 -> rresp=2'b10, rdata=0; write 0x1 to 0x8 -> bresp 0, DATA_IN unchanged.
REQ-039 Write DIR=0xFF with wstrb=4'h0 -> gpio_oe stays 0x00.
REQ-040 Assert rst during W_RESP -> bvalid=0 next cycle, gpio_out=0, awready=1 after rst falls.
